bpu_tournament: RTL and testbench

- Branch prediction unit at the IFU side of the pipeline. It answers fetch-time prediction lookups and consumes the branch-resolution feedback that the execute stage returns.
- Tournament predictor built from three parts:
  - bimodal PHT, indexed by PC;
  - gshare PHT, indexed by PC xor GHR;
  - 2-bit chooser.
- Plus a direct-mapped BTB holding targets and jump types.
- Tables are cleared after reset by an init sweep FSM.

---
 rtl/bpu_tournament_pkg.sv | 20 ++
 rtl/bpu_tournament_sat_cnt2.sv | 25 ++
 rtl/bpu_tournament.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_bpu_tournament.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_tournament_pkg.sv
// Shared definitions for the tournament branch prediction unit.
//   - jump-type encodings carried with BTB entries and update requests
//   - reset/init value of every 2-bit counter (bimodal, gshare, chooser)
//   - state encoding of the table-initialisation FSM
package bpu_tournament_pkg;

    localparam logic [1:0] JT_NONE   = 2'b00;
    localparam logic [1:0] JT_JAL    = 2'b01;
    localparam logic [1:0] JT_JALR   = 2'b10;
    localparam logic [1:0] JT_BRANCH = 2'b11;

    // Weak not-taken for the PHTs, weak bimodal for the chooser.
    localparam logic [1:0] CNT_INIT = 2'b01;

    typedef enum logic {
        BPU_INIT = 1'b0,
        BPU_RUN  = 1'b1
    } bpu_state_e;

endpackage

// File: rtl/bpu_tournament_sat_cnt2.sv
// 2-bit saturating counter next-value function (purely combinational).
// Ports:
//   cnt_i  current counter value
//   inc_i  1 = count up (saturate at 3), 0 = count down (saturate at 0)
//   cnt_o  next counter value
module bpu_sat_cnt2 (
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != 2'b11) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i != 2'b00) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bpu_tournament.sv
// Tournament branch prediction unit (bimodal + gshare + chooser) with a
// direct-mapped BTB. Lookups are answered combinationally in the fetch
// cycle; execute-stage resolutions train the tables on the clock edge.
// After reset an init sweep clears every table, one entry per cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fetch_pc_i/valid_i   lookup request
//   bpu_ready_o          init sweep finished
//   pdt_res_o            predicted taken
//   which_pdt_o          chosen predictor (0 bimodal, 1 gshare)
//   history_o            GHR used for this prediction
//   pdt_tag_o            fetch PC on a BTB hit, else 0
//   pdt_target_o         BTB target on a hit, else 0
//   upd_*                branch resolution feedback from execute
module bpu_tournament
    import bpu_tournament_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int HISLEN  = 8,
    parameter int PHT_IDX = 8,
    parameter int BTB_IDX = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   fetch_pc_i,
    input  logic              fetch_valid_i,
    output logic              bpu_ready_o,
    output logic              pdt_res_o,
    output logic              which_pdt_o,
    output logic [HISLEN-1:0] history_o,
    output logic [XLEN-1:0]   pdt_tag_o,
    output logic [XLEN-1:0]   pdt_target_o,
    input  logic              upd_valid_i,
    input  logic              upd_go_ready_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic [1:0]        upd_jump_type_i,
    input  logic              upd_which_pdt_i,
    input  logic [HISLEN-1:0] upd_history_i,
    input  logic              upd_pdt_correct_i
);

    localparam int          CNT_W = (PHT_IDX > BTB_IDX) ? PHT_IDX : BTB_IDX;
    localparam int unsigned PHT_N = 1 << PHT_IDX;
    localparam int unsigned BTB_N = 1 << BTB_IDX;
    localparam int          TAG_W = XLEN - BTB_IDX - 1;

    // ------------------------------------------------------------------
    // Table storage (no reset: the init sweep clears them)
    // ------------------------------------------------------------------
    logic [1:0]      bim_q     [PHT_N];
    logic [1:0]      gsh_q     [PHT_N];
    logic [1:0]      cho_q     [PHT_N];
    logic            btb_vld_q [BTB_N];
    logic [TAG_W-1:0] btb_tag_q [BTB_N];
    logic [XLEN-1:0] btb_tgt_q [BTB_N];
    logic [1:0]      btb_typ_q [BTB_N];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    bpu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [HISLEN-1:0] ghr_q, ghr_d;
    logic [31:0]       upd_cnt_q, upd_cnt_d;
    logic [31:0]       cor_cnt_q, cor_cnt_d;

    logic run;
    assign run = (state_q == BPU_RUN);

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [PHT_IDX-1:0] f_pidx, f_gidx;
    logic [BTB_IDX-1:0] f_bidx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit, f_which, f_dir, f_jump;

    assign f_pidx = fetch_pc_i[PHT_IDX:1];
    assign f_gidx = f_pidx ^ PHT_IDX'(ghr_q);
    assign f_bidx = fetch_pc_i[BTB_IDX:1];
    assign f_tag  = fetch_pc_i[XLEN-1:BTB_IDX+1];

    always_comb begin
        f_hit   = fetch_valid_i & run & btb_vld_q[f_bidx] & (btb_tag_q[f_bidx] == f_tag);
        f_which = cho_q[f_pidx][1];
        f_dir   = f_which ? gsh_q[f_gidx][1] : bim_q[f_pidx][1];
        f_jump  = (btb_typ_q[f_bidx] == JT_JAL) || (btb_typ_q[f_bidx] == JT_JALR);
    end

    // Chooser and GHR are gated with RUN so nothing leaks out of the
    // tables while they are still being swept (and all outputs read 0
    // straight out of reset).
    always_comb begin
        pdt_res_o    = f_hit & (f_jump | f_dir);
        which_pdt_o  = run & f_which;
        history_o    = run ? ghr_q : '0;
        pdt_tag_o    = f_hit ? fetch_pc_i : '0;
        pdt_target_o = f_hit ? btb_tgt_q[f_bidx] : '0;
    end

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic               upd_fire, upd_branch;
    logic [PHT_IDX-1:0] u_pidx, u_gidx;
    logic [BTB_IDX-1:0] u_bidx;
    logic [1:0]         u_b, u_g, u_c;

    assign upd_fire   = upd_valid_i & upd_go_ready_i & run;
    assign upd_branch = upd_fire & (upd_jump_type_i == JT_BRANCH);
    assign u_pidx     = upd_pc_i[PHT_IDX:1];
    // gshare is retrained at the index it was read from, i.e. with the
    // history that travelled down the pipe, not the current GHR.
    assign u_gidx     = u_pidx ^ PHT_IDX'(upd_history_i);
    assign u_bidx     = upd_pc_i[BTB_IDX:1];

    always_comb begin
        u_b = bim_q[u_pidx];
        u_g = gsh_q[u_gidx];
        u_c = cho_q[u_pidx];
    end

    // Saturating next values: [0] bimodal, [1] gshare, [2] chooser.
    // The chooser moves toward gshare when gshare was right.
    logic [1:0] sc_cnt [3];
    logic       sc_inc [3];
    logic [1:0] sc_nxt [3];

    assign sc_cnt[0] = u_b;
    assign sc_inc[0] = upd_taken_i;
    assign sc_cnt[1] = u_g;
    assign sc_inc[1] = upd_taken_i;
    assign sc_cnt[2] = u_c;
    assign sc_inc[2] = (u_g[1] == upd_taken_i);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sat
            bpu_sat_cnt2 u_sat (
                .cnt_i (sc_cnt[gi]),
                .inc_i (sc_inc[gi]),
                .cnt_o (sc_nxt[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Table write ports: the init sweep owns them in INIT, updates in RUN.
    // ------------------------------------------------------------------
    logic               bim_we, gsh_we, cho_we, btb_we;
    logic [PHT_IDX-1:0] bim_waddr, gsh_waddr, cho_waddr;
    logic [1:0]         bim_wdata, gsh_wdata, cho_wdata;
    logic [BTB_IDX-1:0] btb_waddr;
    logic               btb_wvld;
    logic [TAG_W-1:0]   btb_wtag;
    logic [XLEN-1:0]    btb_wtgt;
    logic [1:0]         btb_wtyp;
    logic               init_in_pht, init_in_btb;

    assign init_in_pht = (32'(init_cnt_q) < PHT_N);
    assign init_in_btb = (32'(init_cnt_q) < BTB_N);

    always_comb begin
        bim_we    = 1'b0;
        gsh_we    = 1'b0;
        cho_we    = 1'b0;
        btb_we    = 1'b0;
        bim_waddr = init_cnt_q[PHT_IDX-1:0];
        gsh_waddr = init_cnt_q[PHT_IDX-1:0];
        cho_waddr = init_cnt_q[PHT_IDX-1:0];
        bim_wdata = CNT_INIT;
        gsh_wdata = CNT_INIT;
        cho_wdata = CNT_INIT;
        btb_waddr = init_cnt_q[BTB_IDX-1:0];
        btb_wvld  = 1'b0;
        btb_wtag  = '0;
        btb_wtgt  = '0;
        btb_wtyp  = JT_NONE;
        if (state_q == BPU_INIT) begin
            bim_we = init_in_pht;
            gsh_we = init_in_pht;
            cho_we = init_in_pht;
            btb_we = init_in_btb;
        end else begin
            bim_we    = upd_branch;
            bim_waddr = u_pidx;
            bim_wdata = sc_nxt[0];
            gsh_we    = upd_branch;
            gsh_waddr = u_gidx;
            gsh_wdata = sc_nxt[1];
            // Chooser only learns when the two predictors disagreed.
            cho_we    = upd_branch & (u_b[1] != u_g[1]);
            cho_waddr = u_pidx;
            cho_wdata = sc_nxt[2];
            // Only taken control flow allocates; not-taken keeps the entry.
            btb_we    = upd_fire & upd_taken_i & (upd_jump_type_i != JT_NONE);
            btb_waddr = u_bidx;
            btb_wvld  = 1'b1;
            btb_wtag  = upd_pc_i[XLEN-1:BTB_IDX+1];
            btb_wtgt  = upd_target_i;
            btb_wtyp  = upd_jump_type_i;
        end
    end

    always_ff @(posedge clk) begin
        if (bim_we) bim_q[bim_waddr] <= bim_wdata;
    end

    always_ff @(posedge clk) begin
        if (gsh_we) gsh_q[gsh_waddr] <= gsh_wdata;
    end

    always_ff @(posedge clk) begin
        if (cho_we) cho_q[cho_waddr] <= cho_wdata;
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_vld_q[btb_waddr] <= btb_wvld;
            btb_tag_q[btb_waddr] <= btb_wtag;
            btb_tgt_q[btb_waddr] <= btb_wtgt;
            btb_typ_q[btb_waddr] <= btb_wtyp;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state logic / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BPU_INIT;
            init_cnt_q <= '0;
            ghr_q      <= '0;
            upd_cnt_q  <= '0;
            cor_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ghr_q      <= ghr_d;
            upd_cnt_q  <= upd_cnt_d;
            cor_cnt_q  <= cor_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            BPU_INIT: begin
                init_cnt_d = init_cnt_q + CNT_W'(1);
                if (init_cnt_q == '1) begin
                    state_d    = BPU_RUN;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d = BPU_RUN;
            end
        endcase
    end

    always_comb begin
        bpu_ready_o = (state_q == BPU_RUN);
    end

    // History is committed at resolution time, branches only.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_branch) begin
            ghr_d = {ghr_q[HISLEN-2:0], upd_taken_i};
        end
    end

    // Debug statistics, saturating at all-ones.
    always_comb begin
        upd_cnt_d = upd_cnt_q;
        cor_cnt_d = cor_cnt_q;
        if (upd_fire && (upd_cnt_q != 32'hFFFF_FFFF)) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
        if (upd_fire && upd_pdt_correct_i && (cor_cnt_q != 32'hFFFF_FFFF)) begin
            cor_cnt_d = cor_cnt_q + 32'd1;
        end
    end

    // Bit 0 of the PCs and the returned which_pdt carry no information here.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i[0], upd_pc_i[0], upd_which_pdt_i};

endmodule

// File: tb/tb_bpu_tournament.sv
module tb_bpu_tournament;

    localparam logic [1:0] T_NONE = 2'b00, T_JAL = 2'b01, T_BR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        bpu_ready, pdt_res, which_pdt;
    logic [7:0]  history;
    logic [31:0] pdt_tag, pdt_target;
    logic        upd_valid, upd_go, upd_taken, upd_which, upd_correct;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic [7:0]  upd_hist;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bpu_tournament #(.XLEN(32), .HISLEN(8), .PHT_IDX(8), .BTB_IDX(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_pc_i        (fetch_pc),
        .fetch_valid_i     (fetch_valid),
        .bpu_ready_o       (bpu_ready),
        .pdt_res_o         (pdt_res),
        .which_pdt_o       (which_pdt),
        .history_o         (history),
        .pdt_tag_o         (pdt_tag),
        .pdt_target_o      (pdt_target),
        .upd_valid_i       (upd_valid),
        .upd_go_ready_i    (upd_go),
        .upd_pc_i          (upd_pc),
        .upd_taken_i       (upd_taken),
        .upd_target_i      (upd_target),
        .upd_jump_type_i   (upd_type),
        .upd_which_pdt_i   (upd_which),
        .upd_history_i     (upd_hist),
        .upd_pdt_correct_i (upd_correct)
    );

    // One update transaction: valid for exactly one rising edge.
    task automatic send_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic [1:0] ty, input logic [7:0] h, input logic go);
        @(negedge clk);
        upd_valid = 1'b1; upd_go = go; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_type = ty; upd_hist = h; upd_correct = 1'b0;
        $display("upd   pc=%h taken=%0d type=%0d hist=%h go=%0d", pc, tk, ty, h, go);
        @(negedge clk);
        upd_valid = 1'b0; upd_go = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        fetch_valid = 1'b1; fetch_pc = pc;
        #1;
        $display("look  pc=%h res=%0d which=%0d hist=%h tag=%h tgt=%h",
                 pc, pdt_res, which_pdt, history, pdt_tag, pdt_target);
    endtask

    task automatic test_reset;
        int cnt;
        int bad_res;
        rst = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h8000_0010;
        upd_valid = 1'b0; upd_go = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_type = T_NONE; upd_which = 1'b0; upd_hist = '0; upd_correct = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bpu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0d exp=0", bpu_ready); end
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL rst_res got=%0d exp=0", pdt_res); end
        checks++; if (which_pdt !== 1'b0) begin errors++; $display("FAIL rst_which got=%0d exp=0", which_pdt); end
        checks++; if (history !== 8'h00) begin errors++; $display("FAIL rst_hist got=%h exp=00", history); end
        checks++; if (pdt_tag !== 32'h0) begin errors++; $display("FAIL rst_tag got=%h exp=0", pdt_tag); end
        checks++; if (pdt_target !== 32'h0) begin errors++; $display("FAIL rst_tgt got=%h exp=0", pdt_target); end
        // Release reset; hold a taken JAL update during the sweep (must be dropped).
        rst = 1'b0;
        upd_valid = 1'b1; upd_go = 1'b1; upd_pc = 32'h8000_0040; upd_taken = 1'b1;
        upd_target = 32'h8000_0999; upd_type = T_JAL;
        cnt = 0; bad_res = 0;
        while (bpu_ready !== 1'b1 && cnt < 1000) begin
            cnt++;
            if (pdt_res !== 1'b0) bad_res++;
            @(negedge clk); #1;
        end
        upd_valid = 1'b0; upd_go = 1'b0; fetch_valid = 1'b0;
        $display("init  sweep cycles=%0d", cnt);
        checks++; if (cnt != 256) begin errors++; $display("FAIL init_len got=%0d exp=256", cnt); end
        checks++; if (bad_res != 0) begin errors++; $display("FAIL init_res got=%0d taken cycles exp=0", bad_res); end
        look(32'h8000_0040);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL init_upd_dropped got=%0d exp=0", pdt_res); end
    endtask

    task automatic test_jal;
        send_upd(32'h8000_0010, 1'b1, 32'h8000_0100, T_JAL, 8'h00, 1'b1);
        look(32'h8000_0010);
        checks++; if (pdt_res !== 1'b1) begin errors++; $display("FAIL jal_res got=%0d exp=1", pdt_res); end
        checks++; if (pdt_target !== 32'h8000_0100) begin errors++; $display("FAIL jal_tgt got=%h exp=80000100", pdt_target); end
        checks++; if (pdt_tag !== 32'h8000_0010) begin errors++; $display("FAIL jal_tag got=%h exp=80000010", pdt_tag); end
        checks++; if (which_pdt !== 1'b0) begin errors++; $display("FAIL jal_which got=%0d exp=0", which_pdt); end
        checks++; if (history !== 8'h00) begin errors++; $display("FAIL jal_hist got=%h exp=00", history); end
    endtask

    task automatic test_branch;
        send_upd(32'h8000_0020, 1'b1, 32'h8000_0080, T_BR, 8'h00, 1'b1);
        send_upd(32'h8000_0020, 1'b1, 32'h8000_0080, T_BR, 8'h00, 1'b1);
        look(32'h8000_0020);
        checks++; if (pdt_res !== 1'b1) begin errors++; $display("FAIL br_res got=%0d exp=1", pdt_res); end
        checks++; if (which_pdt !== 1'b0) begin errors++; $display("FAIL br_which got=%0d exp=0", which_pdt); end
        checks++; if (history !== 8'h03) begin errors++; $display("FAIL br_ghr got=%h exp=03", history); end
        checks++; if (pdt_target !== 32'h8000_0080) begin errors++; $display("FAIL br_tgt got=%h exp=80000080", pdt_target); end
    endtask

    // T,N,T,N... at one PC; bimodal keeps mispredicting, gshare learns,
    // chooser saturates to 3 (reached after the 4th update).
    task automatic test_alternating;
        logic [7:0] h;
        logic tk;
        h = 8'h03;
        for (int i = 0; i < 20; i++) begin
            tk = (i % 2 == 0);
            send_upd(32'h8000_0044, tk, 32'h8000_0300, T_BR, h, 1'b1);
            h = {h[6:0], tk};
        end
        // Next outcome is T: GHR=AA, gshare[22^AA=88]=11.
        look(32'h8000_0044);
        checks++; if (which_pdt !== 1'b1) begin errors++; $display("FAIL alt_which got=%0d exp=1", which_pdt); end
        checks++; if (pdt_res !== 1'b1) begin errors++; $display("FAIL alt_res_t got=%0d exp=1", pdt_res); end
        checks++; if (history !== 8'hAA) begin errors++; $display("FAIL alt_ghr got=%h exp=aa", history); end
        send_upd(32'h8000_0044, 1'b1, 32'h8000_0300, T_BR, 8'hAA, 1'b1);
        // Next outcome is N: GHR=55, gshare[22^55=77]=00 while bimodal says T.
        look(32'h8000_0044);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL alt_res_n got=%0d exp=0", pdt_res); end
        checks++; if (which_pdt !== 1'b1) begin errors++; $display("FAIL alt_which_n got=%0d exp=1", which_pdt); end
        checks++; if (pdt_tag !== 32'h8000_0044) begin errors++; $display("FAIL alt_tag got=%h exp=80000044", pdt_tag); end
    endtask

    task automatic test_go_ready;
        send_upd(32'h8000_0044, 1'b1, 32'h8000_0300, T_BR, 8'h55, 1'b0);
        send_upd(32'h8000_0400, 1'b1, 32'h8000_0500, T_JAL, 8'h55, 1'b0);
        look(32'h8000_0044);
        checks++; if (history !== 8'h55) begin errors++; $display("FAIL go_ghr got=%h exp=55", history); end
        look(32'h8000_0400);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL go_btb got=%0d exp=0", pdt_res); end
        // Same BTB index as 0x80000010, different tag.
        look(32'h8000_0090);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL alias_res got=%0d exp=0", pdt_res); end
        checks++; if (pdt_tag !== 32'h0) begin errors++; $display("FAIL alias_tag got=%h exp=0", pdt_tag); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        fetch_valid = 1'b1; fetch_pc = 32'h8000_00B0;
        upd_valid = 1'b1; upd_go = 1'b1; upd_pc = 32'h8000_00B0; upd_taken = 1'b1;
        upd_target = 32'h8000_0A00; upd_type = T_JAL; upd_hist = 8'h55;
        #1;
        $display("same  pc=%h res=%0d (lookup with update in flight)", fetch_pc, pdt_res);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL same_cycle_old got=%0d exp=0", pdt_res); end
        @(negedge clk);
        upd_valid = 1'b0; upd_go = 1'b0;
        #1;
        $display("next  pc=%h res=%0d tgt=%h", fetch_pc, pdt_res, pdt_target);
        checks++; if (pdt_target !== 32'h8000_0A00) begin errors++; $display("FAIL same_cycle_new got=%h exp=80000a00", pdt_target); end
        send_upd(32'h8000_00C8, 1'b1, 32'h8000_0C00, T_NONE, 8'h55, 1'b1);
        look(32'h8000_00C8);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL none_btb got=%0d exp=0", pdt_res); end
        checks++; if (history !== 8'h55) begin errors++; $display("FAIL none_ghr got=%h exp=55", history); end
    endtask

    task automatic test_rst_run;
        int cnt;
        @(negedge clk);
        rst = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h8000_0010;
        @(negedge clk); #1;
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL rerst_res got=%0d exp=0", pdt_res); end
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (bpu_ready !== 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk); #1;
        end
        $display("init  re-sweep cycles=%0d", cnt);
        checks++; if (cnt != 256) begin errors++; $display("FAIL resweep_len got=%0d exp=256", cnt); end
        look(32'h8000_0010);
        checks++; if (pdt_res !== 1'b0) begin errors++; $display("FAIL rerst_miss got=%0d exp=0", pdt_res); end
        checks++; if (pdt_tag !== 32'h0) begin errors++; $display("FAIL rerst_tag got=%h exp=0", pdt_tag); end
        look(32'h8000_0044);
        checks++; if (which_pdt !== 1'b0) begin errors++; $display("FAIL rerst_cho got=%0d exp=0", which_pdt); end
        checks++; if (history !== 8'h00) begin errors++; $display("FAIL rerst_ghr got=%h exp=00", history); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branch();
        test_alternating();
        test_go_ready();
        test_back_to_back();
        test_rst_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
